// File: rtl/ipcs_pkg.sv
// ============================================================================
// ipcs_pkg : shared types and FIFO word field layout for the ipcs write arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package ipcs_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    localparam int STAT_W = 16;

    // FIFO word = {src, sop, eop, data}
    function automatic int fw_width(input int dw, input int srcw);
        return dw + srcw + 2;
    endfunction

    function automatic int eop_bit(input int dw);
        return dw;
    endfunction

    function automatic int sop_bit(input int dw);
        return dw + 1;
    endfunction

    function automatic int src_lsb(input int dw);
        return dw + 2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ipcs_rr_pick.sv
// ============================================================================
// ipcs_rr_pick : combinational round-robin picker, first set bit at or after ptr
// Rev 1.0
// ============================================================================
`default_nettype none

module ipcs_rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            vld,
    output logic [IW-1:0]   idx
);

    // Walk from the farthest candidate back to ptr so the nearest one wins.
    always_comb begin
        int j;
        j   = 0;
        vld = 1'b0;
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NREQ;
            if (req[j]) begin
                vld = 1'b1;
                idx = IW'(j);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ipcs_wr_arb.sv
// ============================================================================
// ipcs_wr_arb : packet-granular round-robin arbiter for one ipcs_fifo write port
// Optional per-requester packet counters: define IPCS_WR_ARB_STATS_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module ipcs_wr_arb
    import ipcs_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DW      = 64,
    parameter int SRCW    = 2,
    parameter int DEPTH   = 128,
    parameter int PTR     = 7,
    parameter int MAX_PKT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      rq_valid,
    input  logic [NREQ-1:0]      rq_sop,
    input  logic [NREQ-1:0]      rq_eop,
    input  logic [NREQ*DW-1:0]   rq_data,
    output logic [NREQ-1:0]      rq_ready,
    output logic                 fifo_wren,
    output logic [DW+SRCW+1:0]   fifo_din,
    input  logic                 fifo_wrfull,
    input  logic [PTR-1:0]       fifo_wrusedw,
    output logic                 busy,
    output logic [SRCW-1:0]      gnt_id,
    output logic [NREQ*16-1:0]   dbg_pkt_cnt
);

    localparam int FW      = fw_width(DW, SRCW);
    localparam int EOP_B   = eop_bit(DW);
    localparam int SOP_B   = sop_bit(DW);
    localparam int SRC_LSB = src_lsb(DW);

    state_t              state_q, state_d;
    logic [SRCW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [SRCW-1:0]     gnt_id_q, gnt_id_d;
    logic [PTR:0]        free;
    logic [NREQ-1:0]     admit;
    logic                pick_vld;
    logic [SRCW-1:0]     pick_idx;
    logic [FW-1:0]       din_c;

    // wrusedw wraps to 0 when the FIFO is full, so wrfull must override it.
    assign free  = fifo_wrfull ? '0 : ((PTR+1)'(DEPTH) - {1'b0, fifo_wrusedw});
    assign admit = rq_valid & rq_sop;

    ipcs_rr_pick #(
        .NREQ (NREQ),
        .IW   (SRCW)
    ) u_pick (
        .req  (admit),
        .ptr  (rr_ptr_q),
        .vld  (pick_vld),
        .idx  (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        gnt_id_d  = gnt_id_q;
        rq_ready  = '0;
        fifo_wren = 1'b0;
        din_c     = '0;
        case (state_q)
            IDLE: begin
                if (pick_vld && (free >= (PTR+1)'(MAX_PKT))) begin
                    gnt_id_d = pick_idx;
                    state_d  = XFER;
                end
            end
            XFER: begin
                rq_ready[gnt_id_q]          = !fifo_wrfull;
                fifo_wren                   = rq_valid[gnt_id_q] & !fifo_wrfull;
                din_c[DW-1:0]               = rq_data[int'(gnt_id_q)*DW +: DW];
                din_c[EOP_B]                = rq_eop[gnt_id_q];
                din_c[SOP_B]                = rq_sop[gnt_id_q];
                din_c[SRC_LSB +: SRCW]      = gnt_id_q;
                if (fifo_wren && rq_eop[gnt_id_q]) begin
                    state_d  = IDLE;
                    rr_ptr_d = (int'(gnt_id_q) == NREQ - 1) ? '0 : gnt_id_q + SRCW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            gnt_id_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_id_q <= gnt_id_d;
        end
    end

    assign fifo_din = din_c;
    assign busy     = (state_q == XFER);
    assign gnt_id   = gnt_id_q;

`ifdef IPCS_WR_ARB_STATS_EN
    for (genvar i = 0; i < NREQ; i++) begin : g_stats
        logic [STAT_W-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (fifo_wren && rq_eop[i] && (gnt_id_q == SRCW'(i))) begin
                cnt_d = cnt_q + STAT_W'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign dbg_pkt_cnt[i*16 +: 16] = cnt_q;
    end
`else
    assign dbg_pkt_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ipcs_wr_arb.sv
// ============================================================================
// tb_ipcs_wr_arb : scoreboard bench for ipcs_wr_arb (grant order, space, wrfull, reset)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ipcs_wr_arb;

    localparam int NREQ = 4;
    localparam int DW   = 64;
    localparam int SRCW = 2;
    localparam int PTR  = 7;
    localparam int FW   = DW + SRCW + 2;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          sop;
        logic          eop;
    } beat_t;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [NREQ-1:0]     rq_valid = '0;
    logic [NREQ-1:0]     rq_sop = '0;
    logic [NREQ-1:0]     rq_eop = '0;
    logic [NREQ*DW-1:0]  rq_data = '0;
    logic [NREQ-1:0]     rq_ready;
    logic                fifo_wren;
    logic [FW-1:0]       fifo_din;
    logic                fifo_wrfull = 1'b0;
    logic [PTR-1:0]      fifo_wrusedw = '0;
    logic                busy;
    logic [SRCW-1:0]     gnt_id;
    logic [NREQ*16-1:0]  dbg_pkt_cnt;

    logic                rst_v = 1'b1;
    logic                wrfull_v = 1'b0;
    logic [PTR-1:0]      usedw_v = '0;

    beat_t               src_q [NREQ][$];
    logic [FW-1:0]       exp_q [$];
    int                  vectors = 0;
    int                  errors  = 0;

    ipcs_wr_arb #(
        .NREQ(NREQ), .DW(DW), .SRCW(SRCW), .DEPTH(128), .PTR(PTR), .MAX_PKT(16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rq_valid     (rq_valid),
        .rq_sop       (rq_sop),
        .rq_eop       (rq_eop),
        .rq_data      (rq_data),
        .rq_ready     (rq_ready),
        .fifo_wren    (fifo_wren),
        .fifo_din     (fifo_din),
        .fifo_wrfull  (fifo_wrfull),
        .fifo_wrusedw (fifo_wrusedw),
        .busy         (busy),
        .gnt_id       (gnt_id),
        .dbg_pkt_cnt  (dbg_pkt_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Every FIFO write must match the next expected word in order.
    always @(negedge clk) begin
        #2;
        if (fifo_wren === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL fifo_write unexpected din=%h required none", fifo_din);
            end else begin
                logic [FW-1:0] e;
                e = exp_q.pop_front();
                if (fifo_din !== e) begin
                    errors++;
                    $display("FAIL fifo_din got=%h required=%h", fifo_din, e);
                end
            end
        end
    end

    function automatic bit srcs_empty();
        for (int i = 0; i < NREQ; i++) if (src_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // One cycle: drive inputs at negedge, settle, retire accepted beats.
    task automatic tick();
        @(negedge clk);
        reset        = rst_v;
        fifo_wrfull  = wrfull_v;
        fifo_wrusedw = usedw_v;
        for (int i = 0; i < NREQ; i++) begin
            if (src_q[i].size() > 0) begin
                rq_valid[i]            = 1'b1;
                rq_sop[i]              = src_q[i][0].sop;
                rq_eop[i]              = src_q[i][0].eop;
                rq_data[i*DW +: DW]    = src_q[i][0].d;
            end else begin
                rq_valid[i]            = 1'b0;
                rq_sop[i]              = 1'b0;
                rq_eop[i]              = 1'b0;
                rq_data[i*DW +: DW]    = '0;
            end
        end
        #2;
        for (int i = 0; i < NREQ; i++)
            if (rq_valid[i] && rq_ready[i]) void'(src_q[i].pop_front());
    endtask

    task automatic send_pkt(input int r, input int len, input logic [DW-1:0] base);
        beat_t bt;
        for (int b = 0; b < len; b++) begin
            bt.d   = base + DW'(b);
            bt.sop = (b == 0);
            bt.eop = (b == len - 1);
            src_q[r].push_back(bt);
            exp_q.push_back({SRCW'(r), bt.sop, bt.eop, bt.d});
        end
    endtask

    task automatic drain(input string tag);
        int c;
        c = 0;
        while (!(srcs_empty() && busy === 1'b0) && c < 100) begin
            tick();
            c++;
        end
        vectors++;
        if (c >= 100) begin errors++; $display("FAIL %s drain_timeout cycles=%0d limit 100", tag, c); end
        vectors++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL %s leftover_expected=%0d required 0", tag, exp_q.size()); end
    endtask

    task automatic do_reset();
        for (int i = 0; i < NREQ; i++) src_q[i].delete();
        exp_q.delete();
        rst_v = 1'b1;
        tick();
        tick();
        rst_v = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b required 0", busy); end
        vectors++; if (gnt_id !== 2'd0) begin errors++; $display("FAIL rst_gnt_id got=%0d required 0", gnt_id); end
        vectors++; if (rq_ready !== 4'b0) begin errors++; $display("FAIL rst_ready got=%b required 0000", rq_ready); end
        vectors++; if (fifo_wren !== 1'b0) begin errors++; $display("FAIL rst_wren got=%b required 0", fifo_wren); end
        vectors++; if (fifo_din !== '0) begin errors++; $display("FAIL rst_din got=%h required 0", fifo_din); end
        vectors++; if (dbg_pkt_cnt !== '0) begin errors++; $display("FAIL rst_cnt got=%h required 0", dbg_pkt_cnt); end
    endtask

    task automatic test_single_pkt();
        send_pkt(0, 4, 64'h10);
        tick();
        vectors++; if (busy !== 1'b0 || fifo_wren !== 1'b0) begin errors++; $display("FAIL sp_decide busy=%b wren=%b required 0 0", busy, fifo_wren); end
        for (int b = 0; b < 4; b++) begin
            tick();
            vectors++;
            if (busy !== 1'b1 || gnt_id !== 2'd0 || fifo_wren !== 1'b1 || rq_ready !== 4'b0001) begin
                errors++;
                $display("FAIL sp_beat%0d busy=%b gnt=%0d wren=%b ready=%b required 1 0 1 0001", b, busy, gnt_id, fifo_wren, rq_ready);
            end
        end
        tick();
        vectors++; if (busy !== 1'b0 || fifo_wren !== 1'b0) begin errors++; $display("FAIL sp_after busy=%b wren=%b required 0 0", busy, fifo_wren); end
        vectors++; if (exp_q.size() != 0) begin errors++; $display("FAIL sp_leftover got=%0d required 0", exp_q.size()); end
    endtask

    task automatic test_single_beat();
        send_pkt(1, 1, 64'h20);
        tick();
        tick();
        vectors++; if (busy !== 1'b1 || gnt_id !== 2'd1 || fifo_wren !== 1'b1) begin errors++; $display("FAIL sb_xfer busy=%b gnt=%0d wren=%b required 1 1 1", busy, gnt_id, fifo_wren); end
        tick();
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL sb_after busy=%b required 0", busy); end
    endtask

    task automatic test_round_robin();
        int order [8];
        int k, idle, eg;
        bit prev;
        order = '{0, 1, 2, 3, 0, 1, 2, 3};
        do_reset();
        for (int p = 0; p < 2; p++)
            for (int r = 0; r < NREQ; r++) send_pkt(r, 2, DW'(256 + p*16 + r*4));
        k = 0; idle = 0; prev = 1'b0;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (busy === 1'b1 && !prev) begin
                eg = (k < 8) ? order[k] : -1;
                vectors++; if (int'(gnt_id) != eg) begin errors++; $display("FAIL rr_order idx=%0d got=%0d required %0d", k, gnt_id, eg); end
                vectors++; if (idle != 1) begin errors++; $display("FAIL rr_bubble idx=%0d idle=%0d required 1", k, idle); end
                k++;
                idle = 0;
            end else if (busy !== 1'b1) begin
                idle++;
            end
            prev = (busy === 1'b1);
            if (srcs_empty() && busy === 1'b0) break;
        end
        vectors++; if (k != 8) begin errors++; $display("FAIL rr_count got=%0d required 8", k); end
        vectors++; if (exp_q.size() != 0) begin errors++; $display("FAIL rr_leftover got=%0d required 0", exp_q.size()); end
    endtask

    task automatic test_space();
        usedw_v = 7'd113;
        send_pkt(1, 2, 64'h30);
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL space_hold cyc=%0d busy=%b required 0", c, busy); end
        end
        usedw_v = 7'd112;
        tick();
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL space_decide busy=%b required 0", busy); end
        tick();
        vectors++; if (busy !== 1'b1 || gnt_id !== 2'd1) begin errors++; $display("FAIL space_grant busy=%b gnt=%0d required 1 1", busy, gnt_id); end
        drain("space");
        usedw_v = '0;
    endtask

    task automatic test_wrfull();
        send_pkt(2, 5, 64'h40);
        tick();
        tick();
        vectors++; if (fifo_wren !== 1'b1) begin errors++; $display("FAIL wf_beat0 wren=%b required 1", fifo_wren); end
        wrfull_v = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if (rq_ready !== 4'b0 || fifo_wren !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL wf_stall cyc=%0d ready=%b wren=%b busy=%b required 0000 0 1", c, rq_ready, fifo_wren, busy);
            end
        end
        wrfull_v = 1'b0;
        drain("wrfull");
    endtask

    task automatic test_reset_mid();
        send_pkt(3, 5, 64'h50);
        tick();
        tick();
        tick();
        rst_v = 1'b1;
        tick();
        rst_v = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b0 || fifo_wren !== 1'b0 || rq_ready !== 4'b0 || fifo_din !== '0 || gnt_id !== 2'd0) begin
            errors++;
            $display("FAIL rm_reset busy=%b wren=%b ready=%b din=%h gnt=%0d required all 0", busy, fifo_wren, rq_ready, fifo_din, gnt_id);
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            vectors++; if (busy !== 1'b0 || rq_ready !== 4'b0) begin errors++; $display("FAIL rm_nosop cyc=%0d busy=%b ready=%b required 0 0000", c, busy, rq_ready); end
        end
        src_q[3].delete();
        exp_q.delete();
        send_pkt(0, 2, 64'h60);
        send_pkt(1, 2, 64'h70);
        tick();
        tick();
        vectors++; if (busy !== 1'b1 || gnt_id !== 2'd0) begin errors++; $display("FAIL rm_regrant busy=%b gnt=%0d required 1 0", busy, gnt_id); end
        drain("reset_mid");
    endtask

    task automatic test_stats();
        logic [15:0] e;
        do_reset();
        for (int p = 0; p < 3; p++) send_pkt(2, 2, DW'(128 + p*4));
        drain("stats");
        for (int i = 0; i < NREQ; i++) begin
`ifdef IPCS_WR_ARB_STATS_EN
            e = (i == 2) ? 16'd3 : 16'd0;
`else
            e = 16'd0;
`endif
            vectors++;
            if (dbg_pkt_cnt[i*16 +: 16] !== e) begin
                errors++;
                $display("FAIL stats_cnt%0d got=%0d required %0d", i, dbg_pkt_cnt[i*16 +: 16], e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_pkt();
        test_single_beat();
        test_round_robin();
        test_space();
        test_wrfull();
        test_reset_mid();
        test_stats();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ipcs_wr_arb.md
Name: ipcs_wr_arb

Overview:
- Packet-granular round-robin arbiter sharing the single write port of one ipcs_fifo instance among NREQ requesters.
- Admits a packet only when the FIFO has room for a worst-case packet, then locks the grant until eop.
- Tags every beat with source id and sop/eop so the read side can de-interleave.
- Sits on the FIFO write-clock domain; the FIFO's wrclk is driven from clk.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 64, payload width per beat
- SRCW, 2, source-id width; must satisfy 2**SRCW >= NREQ
- DEPTH, 128, depth of the attached FIFO
- PTR, 7, width of wrusedw
- MAX_PKT, 16, maximum packet length in beats; admission threshold
- FW (localparam), DW+SRCW+2, FIFO word width; the FIFO is instantiated with WIDTH=FW

Ports:
- clk  in  1  single clock; also drives FIFO wrclk
- reset  in  1  synchronous, active-high
- rq_valid  in  NREQ  per-requester beat valid
- rq_sop  in  NREQ  first beat of packet
- rq_eop  in  NREQ  last beat of packet
- rq_data  in  NREQ*DW  payloads; requester i occupies bits [i*DW +: DW]
- rq_ready  out  NREQ  beat accepted when rq_valid&rq_ready
- fifo_wren  out  1  to FIFO wren
- fifo_din  out  FW  to FIFO datain = {src[SRCW-1:0], sop, eop, data[DW-1:0]}
- fifo_wrfull  in  1  from FIFO wrfull
- fifo_wrusedw  in  PTR  from FIFO wrusedw
- busy  out  1  grant held
- gnt_id  out  SRCW  current or last grant holder
- dbg_pkt_cnt  out  NREQ*16  per-requester packet counters (see Optional Feature)

Behaviour:
- Reset: state=IDLE, rr_ptr=0, gnt_id=0, busy=0, rq_ready=0, fifo_wren=0, fifo_din=0, counters=0.
- Reset mid-packet abandons the packet: the FIFO holds a partial packet with no eop. Reset the FIFO together with the arbiter.
- free = fifo_wrfull ? 0 : DEPTH - fifo_wrusedw, computed PTR+1 bits wide. The case wrusedw=0 with wrfull=0 means DEPTH free.
- Admissible requester: rq_valid[i] & rq_sop[i].
- Admission requires free >= MAX_PKT.
- IDLE:
  - If any requester is admissible and space is sufficient, pick the first admissible index starting at rr_ptr, wrapping modulo NREQ.
  - Register gnt_id; busy=1; go to XFER. Grant latency is 1 cycle; no beat is accepted in the decision cycle.
  - A requester presenting valid without sop in IDLE is a protocol error: it is never granted and its rq_ready stays 0.
- XFER:
  - rq_ready[gnt_id] = !fifo_wrfull. This is combinational; all other ready bits are 0.
  - fifo_wren = rq_valid[gnt_id] & !fifo_wrfull (combinational). fifo_din carries the granted requester's fields.
  - sop is taken from the requester and is not regenerated.
  - On an accepted beat with eop: rr_ptr = gnt_id+1 (mod NREQ), busy=0, go to IDLE. This forces one bubble cycle between packets.
  - Valid low mid-packet holds the grant indefinitely; there is no timeout.
  - A single-beat packet (sop & eop) is legal: 1 cycle in XFER.
  - Packets longer than MAX_PKT are not truncated, but the space guarantee is void. wrfull still prevents overwrite.
- fifo_wrfull is honoured every beat regardless of admission.
- Simultaneous eop on the granted requester and new sop elsewhere: the new grant is decided in the following IDLE cycle.

Optional Feature:
- Macro IPCS_WR_ARB_STATS_EN.
- Defined: dbg_pkt_cnt[i*16 +: 16] increments on each accepted eop beat from requester i. The counter wraps at 0xFFFF→0 and is cleared by reset.
- Undefined: dbg_pkt_cnt is tied to 0 and no counter flops are inferred.

Decomposition:
- Shared package ipcs_pkg holds:
  - FW computation function
  - field offsets (SRC_LSB, SOP_BIT=DW+1, EOP_BIT=DW)
  - state encoding IDLE=1'b0, XFER=1'b1
- One sub-module: ipcs_rr_pick. It is purely combinational: inputs are a NREQ-bit request vector and rr_ptr; outputs are a valid flag and the selected index.

Test Plan:
- Req0 sends a 4-beat packet into an empty FIFO, data 0x10..0x13 → grant 1 cycle after sop. Expect 4 fifo_wren cycles with fifo_din={0,1,0,0x10}…{0,0,1,0x13}, then busy=0.
- Req0..3 all hold sop continuously with 2-beat packets, rr_ptr=0 → grant order 0,1,2,3,0. Exactly one idle cycle between packets.
- fifo_wrusedw=113 (free 15 < MAX_PKT=16) with req1 sop → no grant. Lower to 112 → grant on the next cycle.
- Force fifo_wrfull=1 for 3 cycles mid-packet → rq_ready and fifo_wren are 0 for those cycles, and no beat is lost or duplicated.
- Assert reset for 1 cycle during beat 2 of 5 → all outputs return to reset values the next cycle, and the next grant starts at req0.
- With IPCS_WR_ARB_STATS_EN defined: req2 sends 3 packets → dbg_pkt_cnt[47:32]=3, all other counters 0. Without the macro, all counters read 0.
